mem_1r1w_masked_banked: RTL
===========================

MEM_1R1W_MASKED_BANKED -- requirements
Module: mem_1r1w_masked_banked

Interface
REQ-001 Parameter DEPTH, default 48; number of logical words.
REQ-002 Parameter WIDTH, default 64; logical word width in bits.
REQ-003 Parameter MASK_GRAN, default 8; bits per write-mask lane; WIDTH SHALL be a multiple of MASK_GRAN.
REQ-004 Parameter BANK_DEPTH, default 32; words per hard-macro bank; NBANKS = ceil(DEPTH/BANK_DEPTH), AW = clog2(DEPTH), MW = WIDTH/MASK_GRAN.
REQ-005 Parameter OUT_REG, default 0; 1 adds one output pipeline stage.
REQ-006 clk  input  1  single clock for read and write ports.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 R0_addr  input  AW  read word address.
REQ-009 R0_en  input  1  read request.
REQ-010 R0_data  output  WIDTH  read data.
REQ-011 R0_valid  output  1  R0_data holds the result of an accepted read.
REQ-012 W0_addr  input  AW  write word address.
REQ-013 W0_en  input  1  write request.
REQ-014 W0_data  input  WIDTH  write data.
REQ-015 W0_mask  input  MW  per-lane write enable; bit i covers bits [i*MASK_GRAN +: MASK_GRAN].
REQ-016 oor_cnt  output  8  saturating count of out-of-range accesses.

Function
REQ-017 Bank select = addr / BANK_DEPTH; in-bank address = addr % BANK_DEPTH; only the selected bank's macro chip-enable SHALL be active.
REQ-018 Write with W0_en=1 and W0_addr<DEPTH SHALL update only the masked lanes of the addressed word at the rising edge; W0_mask=0 SHALL leave memory unchanged.
REQ-019 Read latency SHALL be 1+OUT_REG cycles: R0_valid asserts exactly 1+OUT_REG cycles after the cycle R0_en=1 is sampled, and stays high one cycle per request.
REQ-020 Back-to-back reads SHALL be accepted every cycle with no bubbles.
REQ-021 Bank index and collision information SHALL be registered with the request and travel with it through the OUT_REG stage.
REQ-022 Same-cycle read and write to the same in-range address SHALL be write-first: masked lanes return W0_data, unmasked lanes return the old stored data.
REQ-023 A read with R0_addr>=DEPTH SHALL return all zeros with R0_valid asserted, and SHALL enable no macro.
REQ-024 A write with W0_addr>=DEPTH SHALL be dropped and enable no macro.
REQ-025 oor_cnt SHALL increment by 1 per cycle with an out-of-range read or write, by 2 when both occur in one cycle, and SHALL saturate at 255.
REQ-026 R0_data SHALL be 0 whenever R0_valid=0.
REQ-027 Macro test and DFT pins SHALL be tied to functional mode; COLLDISN SHALL be 1; EMA pins SHALL be constants.

Reset
REQ-028 Asserting rst_n low SHALL immediately clear R0_valid, oor_cnt, the pipeline and collision registers, and force R0_data to 0.
REQ-029 Reads in flight at reset SHALL be discarded; memory contents are not reset and SHALL NOT be relied on afterwards.
REQ-030 The first read accepted after rst_n deasserts SHALL follow REQ-019 exactly.

Structure
REQ-031 A shared package SHALL hold the bank-index and address-split functions, the NBANKS/MW derivation, and the macro tie-off constants (EMA values, test-pin values).
REQ-032 One sub-module, mem_bank_macro, SHALL wrap one vendor 2-port masked macro with active-low enable and mask conversion; it is instantiated NBANKS times via generate.
REQ-033 mem_bank_macro SHALL have a behavioural simulation body selected by a define, with 1-cycle read latency and read-first collision (the top-level bypass supplies write-first).

Verification
REQ-034 Write 0x0123456789ABCDEF to address 5 with mask 0xFF, then read 5 -> R0_valid at +1 cycle (OUT_REG=0), data 0x0123456789ABCDEF.
REQ-035 Preload address 40 = all-ones, write 0 with mask 0x0F, then read 40 -> 0xFFFFFFFF00000000.
REQ-036 In the same cycle, write 0xAAAA_AAAA_AAAA_AAAA with mask 0xF0 to address 33 and read address 33 (old value 0) -> 0xAAAAAAAA00000000.
REQ-037 Read address 50 and write address 60 in the same cycle -> R0_data=0 with R0_valid=1, oor_cnt +2, no macro enable asserted; 300 such cycles -> oor_cnt=255.
REQ-038 OUT_REG=1: reads of addresses 0, 31, 32, 47 on consecutive cycles -> four valid results at +2..+5 cycles, in order, with the correct bank each.
REQ-039 Assert rst_n low while two reads are in flight -> R0_valid=0 and R0_data=0 immediately, no stale valid after release.

Source files
------------

// File: rtl/mem_1r1w_masked_banked_pkg.sv
// Shared helpers for the banked 1R1W masked memory: bank/address split,
// derived sizes and the hard-macro tie-off constants.
package mem_1r1w_masked_banked_pkg;

  // Macro timing-margin and test/DFT pins, fixed to functional mode.
  localparam logic [2:0] EMAA_VAL     = 3'b010;
  localparam logic [2:0] EMAB_VAL     = 3'b010;
  localparam logic       EMASA_VAL    = 1'b0;
  localparam logic       TEN_VAL      = 1'b1;
  localparam logic       BEN_VAL      = 1'b1;
  localparam logic       RET1N_VAL    = 1'b1;
  localparam logic       COLLDISN_VAL = 1'b1;

  function automatic int calc_nbanks(input int depth, input int bank_depth);
    return (depth + bank_depth - 1) / bank_depth;
  endfunction

  function automatic int calc_mw(input int width, input int mask_gran);
    return width / mask_gran;
  endfunction

  function automatic int bank_of(input int addr, input int bank_depth);
    return addr / bank_depth;
  endfunction

  function automatic int offset_of(input int addr, input int bank_depth);
    return addr % bank_depth;
  endfunction

endpackage

// File: rtl/mem_1r1w_masked_banked_bank.sv
// One 2-port masked macro bank: converts to active-low enables and a per-bit
// active-low write mask. The behavioural body is read-first with 1-cycle latency.
module mem_bank_macro
  import mem_1r1w_masked_banked_pkg::*;
#(
  parameter int BANK_DEPTH = 32,
  parameter int WIDTH      = 64,
  parameter int MASK_GRAN  = 8,
  parameter int MW         = 8,
  parameter int BAW        = 5
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [BAW-1:0]   rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [BAW-1:0]   wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [MW-1:0]    wr_mask
);

  logic             cena_n;
  logic             cenb_n;
  logic [WIDTH-1:0] wenb_n;

  assign cena_n = ~rd_en;
  assign cenb_n = ~wr_en;

  for (genvar gi = 0; gi < MW; gi++) begin : g_mask
    assign wenb_n[gi*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{~wr_mask[gi]}};
  end

`ifndef MEM_VENDOR_MACRO
  logic [WIDTH-1:0] mem_q [BANK_DEPTH];
  logic [WIDTH-1:0] qa_q;

  always_ff @(posedge clk) begin
    if (!cena_n) qa_q <= mem_q[rd_addr];
    if (!cenb_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!wenb_n[i]) mem_q[wr_addr][i] <= wr_data[i];
      end
    end
  end

  assign rd_data = qa_q;
`else
  vendor_sram_2p_masked u_macro (
    .CLKA     (clk),
    .CENA     (cena_n),
    .AA       (rd_addr),
    .QA       (rd_data),
    .CLKB     (clk),
    .CENB     (cenb_n),
    .WENB     (wenb_n),
    .AB       (wr_addr),
    .DB       (wr_data),
    .EMAA     (EMAA_VAL),
    .EMAB     (EMAB_VAL),
    .EMASA    (EMASA_VAL),
    .TENA     (TEN_VAL),
    .TENB     (TEN_VAL),
    .BENA     (BEN_VAL),
    .RET1N    (RET1N_VAL),
    .COLLDISN (COLLDISN_VAL)
  );
`endif

endmodule

// File: rtl/mem_1r1w_masked_banked.sv
// Banked 1R1W memory with lane write mask, write-first bypass, out-of-range
// handling (zero data, no macro access, saturating counter) and optional output stage.
module mem_1r1w_masked_banked
  import mem_1r1w_masked_banked_pkg::*;
#(
  parameter  int DEPTH      = 48,
  parameter  int WIDTH      = 64,
  parameter  int MASK_GRAN  = 8,
  parameter  int BANK_DEPTH = 32,
  parameter  int OUT_REG    = 0,
  localparam int AW         = $clog2(DEPTH),
  localparam int MW         = calc_mw(WIDTH, MASK_GRAN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    R0_addr,
  input  logic             R0_en,
  output logic [WIDTH-1:0] R0_data,
  output logic             R0_valid,
  input  logic [AW-1:0]    W0_addr,
  input  logic             W0_en,
  input  logic [WIDTH-1:0] W0_data,
  input  logic [MW-1:0]    W0_mask,
  output logic [7:0]       oor_cnt
);

  localparam int NBANKS = calc_nbanks(DEPTH, BANK_DEPTH);
  localparam int BW     = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int BAW    = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;

  logic              r_in, w_in, r_oor, w_oor;
  logic [BW-1:0]     r_bank, w_bank;
  logic [BAW-1:0]    r_off, w_off;
  logic [NBANKS-1:0] rd_ce, wr_ce;
  logic [WIDTH-1:0]  bank_rdata [NBANKS];

  always_comb begin
    r_in   = int'(R0_addr) < DEPTH;
    w_in   = int'(W0_addr) < DEPTH;
    r_oor  = R0_en && !r_in;
    w_oor  = W0_en && !w_in;
    r_bank = BW'(bank_of(int'(R0_addr), BANK_DEPTH));
    w_bank = BW'(bank_of(int'(W0_addr), BANK_DEPTH));
    r_off  = BAW'(offset_of(int'(R0_addr), BANK_DEPTH));
    w_off  = BAW'(offset_of(int'(W0_addr), BANK_DEPTH));
  end

  for (genvar gi = 0; gi < NBANKS; gi++) begin : g_bank
    // A zero mask writes nothing, so the write macro stays idle.
    assign rd_ce[gi] = R0_en && r_in && (r_bank == BW'(gi));
    assign wr_ce[gi] = W0_en && w_in && (|W0_mask) && (w_bank == BW'(gi));

    mem_bank_macro #(
      .BANK_DEPTH (BANK_DEPTH),
      .WIDTH      (WIDTH),
      .MASK_GRAN  (MASK_GRAN),
      .MW         (MW),
      .BAW        (BAW)
    ) u_bank (
      .clk     (clk),
      .rd_en   (rd_ce[gi]),
      .rd_addr (r_off),
      .rd_data (bank_rdata[gi]),
      .wr_en   (wr_ce[gi]),
      .wr_addr (w_off),
      .wr_data (W0_data),
      .wr_mask (W0_mask)
    );
  end

  logic             s1_vld_q, s1_vld_d, s1_oor_q, s1_oor_d;
  logic [BW-1:0]    s1_bank_q, s1_bank_d;
  logic [MW-1:0]    s1_coll_q, s1_coll_d;
  logic [WIDTH-1:0] s1_byp_q, s1_byp_d, s1_data;
  logic [7:0]       oor_cnt_q, oor_cnt_d;
  logic [8:0]       oor_sum;

  always_comb begin
    s1_vld_d  = R0_en;
    s1_oor_d  = r_oor;
    s1_bank_d = r_bank;
    s1_coll_d = '0;
    s1_byp_d  = s1_byp_q;
    // Macros are read-first; the bypass turns a same-address hit into write-first.
    if (R0_en && r_in && W0_en && w_in && (R0_addr == W0_addr)) begin
      s1_coll_d = W0_mask;
      s1_byp_d  = W0_data;
    end
    oor_sum   = {1'b0, oor_cnt_q} + 9'(r_oor) + 9'(w_oor);
    oor_cnt_d = oor_sum[8] ? 8'hFF : oor_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_oor_q  <= 1'b0;
      s1_bank_q <= '0;
      s1_coll_q <= '0;
      s1_byp_q  <= '0;
      oor_cnt_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_oor_q  <= s1_oor_d;
      s1_bank_q <= s1_bank_d;
      s1_coll_q <= s1_coll_d;
      s1_byp_q  <= s1_byp_d;
      oor_cnt_q <= oor_cnt_d;
    end
  end

  always_comb begin
    s1_data = '0;
    if (s1_vld_q && !s1_oor_q) begin
      s1_data = bank_rdata[s1_bank_q];
      for (int l = 0; l < MW; l++) begin
        if (s1_coll_q[l]) s1_data[l*MASK_GRAN +: MASK_GRAN] = s1_byp_q[l*MASK_GRAN +: MASK_GRAN];
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    always_comb begin
      out_vld_d  = s1_vld_q;
      out_data_d = s1_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_vld_q  <= 1'b0;
        out_data_q <= '0;
      end else begin
        out_vld_q  <= out_vld_d;
        out_data_q <= out_data_d;
      end
    end

    assign R0_valid = out_vld_q;
    assign R0_data  = out_data_q;
  end else begin : g_no_out_reg
    assign R0_valid = s1_vld_q;
    assign R0_data  = s1_data;
  end

  assign oor_cnt = oor_cnt_q;

endmodule
